// File: rtl/tablero_pkg.sv
// Shared encodings, FSM states and line geometry for the tic-tac-toe board.
package tablero_pkg;

  localparam int unsigned NUM_CELDAS    = 9;
  localparam int unsigned NUM_LINEAS    = 8;
  localparam int unsigned ANCHO_CELDA   = 2;
  localparam int unsigned ANCHO_TABLERO = NUM_CELDAS * ANCHO_CELDA;
  localparam int unsigned ANCHO_POS     = 4;

  // Cell contents
  localparam logic [1:0] VACIA   = 2'b00;
  localparam logic [1:0] MARCA_X = 2'b01;
  localparam logic [1:0] MARCA_O = 2'b10;

  // Game result encodings
  localparam logic [1:0] NINGUNO = 2'b00;
  localparam logic [1:0] GANA_X  = 2'b01;
  localparam logic [1:0] GANA_O  = 2'b10;
  localparam logic [1:0] EMPATE  = 2'b11;

  typedef enum logic [1:0] {
    JUGANDO = 2'd0,
    EVALUAR = 2'd1,
    FIN     = 2'd2
  } estado_t;

  // Cell triplets of each line; index order matches the linea_ganadora bits
  localparam logic [3:0] LINEAS [0:7][0:2] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Read one cell of the packed board; out-of-range indices read as empty
  function automatic logic [1:0] leer_celda(input logic [ANCHO_TABLERO-1:0] tab,
                                            input logic [ANCHO_POS-1:0]     idx);
    leer_celda = VACIA;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) leer_celda = tab[2*i +: 2];
    end
  endfunction

endpackage

// File: rtl/detector_linea.sv
// Combinational win/draw detector over the registered board.
module detector_linea
  import tablero_pkg::*;
(
  input  logic [ANCHO_TABLERO-1:0] tablero,
  output logic                     hay_linea,
  output logic [1:0]               marca,
  output logic [NUM_LINEAS-1:0]    linea,
  output logic                     lleno
);

  logic [1:0] c0, c1, c2;

  // Scan lines in index order so the lowest-index completed line is reported
  always_comb begin
    hay_linea = 1'b0;
    marca     = VACIA;
    linea     = '0;
    c0        = VACIA;
    c1        = VACIA;
    c2        = VACIA;
    for (int l = 0; l < 8; l++) begin
      c0 = leer_celda(tablero, LINEAS[l][0]);
      c1 = leer_celda(tablero, LINEAS[l][1]);
      c2 = leer_celda(tablero, LINEAS[l][2]);
      if (!hay_linea && (c0 != VACIA) && (c0 == c1) && (c1 == c2)) begin
        hay_linea   = 1'b1;
        marca       = c0;
        linea[3'(l)] = 1'b1;
      end
    end
  end

  // Board is full when no cell is empty
  always_comb begin
    lleno = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (tablero[2*i +: 2] == VACIA) lleno = 1'b0;
    end
  end

endmodule

// File: rtl/tablero_juego.sv
// 3x3 tic-tac-toe board: accepts moves, alternates turns, detects win/draw.
module tablero_juego
  import tablero_pkg::*;
#(
  parameter bit PRIMER_JUGADOR = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ANCHO_POS-1:0]     posicion,
  input  logic                     colocar,
  input  logic                     nuevo_juego,
  output logic [ANCHO_TABLERO-1:0] tablero,
  output logic                     turno,
  output logic [1:0]               ganador,
  output logic                     fin,
  output logic [NUM_LINEAS-1:0]    linea_ganadora,
  output logic                     invalida
);

  estado_t                 estado;
  logic [1:0]              celda_actual;
  logic                    pos_valida;
  logic [1:0]              marca_turno;
  logic                    hay_linea;
  logic [1:0]              marca_linea;
  logic [NUM_LINEAS-1:0]   linea_det;
  logic                    lleno;

  detector_linea u_detector (
    .tablero   (tablero),
    .hay_linea (hay_linea),
    .marca     (marca_linea),
    .linea     (linea_det),
    .lleno     (lleno)
  );

  // Decode the cursor cell and the mark of the player to move
  always_comb begin
    pos_valida   = (posicion <= 4'd8);
    celda_actual = leer_celda(tablero, posicion);
    marca_turno  = turno ? MARCA_O : MARCA_X;
  end

  // Game FSM with board, turn and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado         <= JUGANDO;
      tablero        <= '0;
      turno          <= PRIMER_JUGADOR;
      ganador        <= NINGUNO;
      fin            <= 1'b0;
      linea_ganadora <= '0;
      invalida       <= 1'b0;
    end else begin
      invalida <= 1'b0;
      if (nuevo_juego) begin
        estado         <= JUGANDO;
        tablero        <= '0;
        turno          <= PRIMER_JUGADOR;
        ganador        <= NINGUNO;
        fin            <= 1'b0;
        linea_ganadora <= '0;
      end else begin
        case (estado)
          JUGANDO: begin
            if (colocar) begin
              if (pos_valida && (celda_actual == VACIA)) begin
                for (int i = 0; i < 9; i++) begin
                  if (posicion == 4'(i)) tablero[2*i +: 2] <= marca_turno;
                end
                estado <= EVALUAR;
              end else begin
                invalida <= 1'b1;
              end
            end
          end
          EVALUAR: begin
            if (hay_linea) begin
              ganador        <= (marca_linea == MARCA_O) ? GANA_O : GANA_X;
              linea_ganadora <= linea_det;
              fin            <= 1'b1;
              estado         <= FIN;
            end else if (lleno) begin
              ganador        <= EMPATE;
              linea_ganadora <= '0;
              fin            <= 1'b1;
              estado         <= FIN;
            end else begin
              turno  <= ~turno;
              estado <= JUGANDO;
            end
          end
          FIN: begin
            estado <= FIN;
          end
          default: begin
            estado <= JUGANDO;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/tablero_juego.md
Name: tablero_juego

Overview:
- Downstream consumer of the cursor FSM's 4-bit cell position (0..8). Holds the 3x3 tic-tac-toe board and alternates turns between X and O.
- On a "place" pulse it writes the current player's mark into the cursor cell, evaluates win/draw and then hands the turn over.
- Its outputs feed the VGA renderer (board contents, winning line highlight) and the status display.

Parameters:
- PRIMER_JUGADOR, 0, player who moves first after reset or new game (0 = X, 1 = O).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- posicion  input  4  cursor cell index from cursor FSM; valid range 0..8
- colocar  input  1  single-cycle place request (already debounced/edge-detected upstream)
- nuevo_juego  input  1  synchronous new-game request, single-cycle
- tablero  output  18  2 bits per cell, cell i at [2i+1:2i]; 00 empty, 01 X, 10 O, 11 never produced
- turno  output  1  player to move (0 = X, 1 = O)
- ganador  output  2  00 none, 01 X won, 10 O won, 11 draw
- fin  output  1  game over (win or draw)
- linea_ganadora  output  8  one-hot winning line: bits 0-2 rows 0-2, bits 3-5 columns 0-2, bit 6 main diagonal (0,4,8), bit 7 anti-diagonal (2,4,6)
- invalida  output  1  one-cycle pulse: a place request was rejected

Behaviour:
- Reset (rst low, async):
  - tablero = 0, turno = PRIMER_JUGADOR, ganador = 00, fin = 0, linea_ganadora = 0, invalida = 0.
  - State = JUGANDO.
- States: JUGANDO, EVALUAR, FIN.
- JUGANDO:
  - A place is accepted when colocar = 1, posicion <= 8 and the cell is 00.
  - Accepted place in cycle t: the cell is written with the turno mark (X = 01, O = 10), visible on tablero from cycle t+1; the next state is EVALUAR.
  - Rejected place (posicion > 8 or cell occupied): no write, invalida = 1 in cycle t+1 only, state unchanged.
- EVALUAR (exactly one cycle, operating on the registered board):
  - Check all 8 lines for three equal non-empty marks.
  - Win: ganador = mark of the player who just moved, linea_ganadora = one-hot line, fin = 1, turno unchanged, next state FIN.
  - A move can complete two lines at once (e.g. row and diagonal through a shared cell). Only the lowest-index line is reported.
  - No win and all 9 cells non-empty: ganador = 11, fin = 1, linea_ganadora = 0, next state FIN.
  - Otherwise: turno toggles, next state JUGANDO.
  - Result timing: accept in cycle t, result visible in cycle t+2.
- FIN: colocar is ignored, with no invalida pulse. Outputs are held until nuevo_juego or reset.
- colocar during EVALUAR: ignored, with no invalida pulse.
- nuevo_juego (any state):
  - Next cycle: tablero = 0, turno = PRIMER_JUGADOR, ganador = 00, fin = 0, linea_ganadora = 0, state JUGANDO.
  - It has priority over a simultaneous colocar, which is dropped with no invalida pulse.
- Reset asserted mid-EVALUAR: everything returns to reset values immediately; the pending evaluation is discarded.
- The block does not modify posicion; the cursor keeps moving independently of the turn.

Decomposition:
- Package tablero_pkg:
  - Cell encoding constants VACIA, MARCA_X, MARCA_O.
  - ganador encodings NINGUNO, GANA_X, GANA_O, EMPATE.
  - Enum estado_t {JUGANDO, EVALUAR, FIN}.
  - Constant array of the 8 line triplets of cell indices.
- Sub-module detector_linea (combinational): takes tablero and returns win flag, winning mark and one-hot line (lowest index wins), plus a board-full flag. The top level holds the FSM, the board register and the turn register.

Test Plan:
- Reset, then colocar at posicion 4 → tablero[9:8] = 01 at t+1; turno 0 → 1 at t+2; invalida stays 0.
- X at 0, O at 3, X at 1, O at 4, X at 2 → at t+2 of the final move: ganador = 01, fin = 1, linea_ganadora = 8'b0000_0001, turno = 0; a further colocar at 8 leaves tablero unchanged and invalida = 0.
- Place at 4, then O attempts 4 → invalida pulses for exactly one cycle; tablero unchanged; turno stays 1. Then colocar with posicion = 9 → invalida pulses again.
- Fill sequence 0,1,2,4,3,5,7,6,8 (X,O,X,O,X,O,X,O,X) → after the 9th move: ganador = 11, fin = 1, linea_ganadora = 0.
- Mid-game, nuevo_juego and colocar asserted in the same cycle → next cycle tablero = 0, turno = PRIMER_JUGADOR, no write, no invalida pulse. Repeat with PRIMER_JUGADOR = 1: the first accepted mark is 10.
- Assert rst during the EVALUAR cycle of a winning move → all outputs go to reset values asynchronously; after release, fin = 0 and ganador = 00.
